// File: rtl/aq_djpeg_pkg.sv
// Shared constants and helpers for the aq_djpeg frame-buffer write path.
// The FIFO entry layout is {addr[31:0], data[31:0], last}.
package aq_djpeg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fbwr_state_e;

    localparam int         FBWR_BPP_SHIFT = 2;
    localparam logic [7:0] FBWR_PAD       = 8'h00;

    localparam int ADDR_LSB = 33;
    localparam int DATA_LSB = 1;
    localparam int LAST_BIT = 0;
    localparam int ENTRY_W  = 65;

    // Byte offset of pixel (x, y) in a frame of width w; wraps modulo 2^32.
    function automatic logic [31:0] fbwr_offset(input logic [15:0] w,
                                                input logic [15:0] y,
                                                input logic [15:0] x);
        logic [31:0] lin;
        lin = ({16'h0000, w} * {16'h0000, y}) + {16'h0000, x};
        return lin << FBWR_BPP_SHIFT;
    endfunction

endpackage

// File: rtl/aq_djpeg_fbwr_if.sv
// Valid/ready memory-write port of the frame-buffer writer.
interface aq_djpeg_fbwr_if;
    logic        WrValid;
    logic        WrReady;
    logic [31:0] WrAddr;
    logic [31:0] WrData;

    modport master (output WrValid, output WrAddr, output WrData, input WrReady);
    modport slave  (input WrValid, input WrAddr, input WrData, output WrReady);
endinterface

// File: rtl/aq_djpeg_sfifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy output.
// The head word reads as zero while the FIFO is empty.
module aq_djpeg_sfifo #(
    parameter int WIDTH = 65,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    // level never exceeds DEPTH, so its MSB alone marks a full FIFO
    assign full  = level[AW];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/aq_djpeg_fbwr.sv
// Frame-buffer write adapter: decoder pixels -> two-stage address pipeline ->
// FIFO -> valid/ready write port, with sticky overflow and frame-done pulse.
module aq_djpeg_fbwr
    import aq_djpeg_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        BaseAddr,
    input  logic               FrameStart,
    input  logic               OutEnable,
    input  logic [15:0]        OutWidth,
    input  logic [15:0]        OutHeight,
    input  logic [15:0]        OutPixelX,
    input  logic [15:0]        OutPixelY,
    input  logic [7:0]         OutR,
    input  logic [7:0]         OutG,
    input  logic [7:0]         OutB,
    aq_djpeg_fbwr_if.master    wr,
    output logic               Overflow,
    output logic               FrameDone,
    output logic [FIFO_AW:0]   FifoLevel
);
    fbwr_state_e state_q, state_d;
    logic        accept_en;

    logic [31:0] base_q;
    logic        s1_vld_q;
    logic [15:0] s1_w_q, s1_x_q, s1_y_q;
    logic [23:0] s1_rgb_q;
    logic        s1_last_q;
    logic        s2_vld_q;
    logic [ENTRY_W-1:0] s2_entry_q, s2_entry_d;

    logic [ENTRY_W-1:0] head;
    logic        fifo_full, fifo_empty;
    logic        pop, done_hit, pix_ok;
    logic        overflow_q, done_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (FrameStart) state_d = ST_RUN;
            ST_RUN: begin
                if (FrameStart)    state_d = ST_RUN;
                else if (done_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A FrameStart cycle never accepts a pixel: the restart wins.
    always_comb begin
        accept_en = 1'b0;
        if (state_q == ST_RUN && !FrameStart) accept_en = 1'b1;
    end

    assign pix_ok = accept_en && OutEnable &&
                    (OutPixelX < OutWidth) && (OutPixelY < OutHeight);

    always_ff @(posedge clk) begin
        if (rst)             base_q <= '0;
        else if (FrameStart) base_q <= BaseAddr;
    end

    always_ff @(posedge clk) begin
        if (rst || FrameStart) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= pix_ok;
            s2_vld_q <= s1_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_w_q     <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_rgb_q   <= '0;
            s1_last_q  <= 1'b0;
            s2_entry_q <= '0;
        end else begin
            if (pix_ok) begin
                s1_w_q    <= OutWidth;
                s1_x_q    <= OutPixelX;
                s1_y_q    <= OutPixelY;
                s1_rgb_q  <= {OutR, OutG, OutB};
                s1_last_q <= (OutPixelX == OutWidth - 16'd1) &&
                             (OutPixelY == OutHeight - 16'd1);
            end
            if (s1_vld_q) s2_entry_q <= s2_entry_d;
        end
    end

    always_comb begin
        s2_entry_d = '0;
        s2_entry_d[ADDR_LSB +: 32] = base_q + fbwr_offset(s1_w_q, s1_y_q, s1_x_q);
        s2_entry_d[DATA_LSB +: 32] = {FBWR_PAD, s1_rgb_q};
        s2_entry_d[LAST_BIT]       = s1_last_q;
    end

    aq_djpeg_sfifo #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (FrameStart),
        .push  (s2_vld_q),
        .pop   (pop),
        .din   (s2_entry_q),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FifoLevel)
    );

    assign wr.WrValid = !fifo_empty;
    assign wr.WrAddr  = head[ADDR_LSB +: 32];
    assign wr.WrData  = head[DATA_LSB +: 32];
    assign pop        = wr.WrValid && wr.WrReady;
    assign done_hit   = pop && head[LAST_BIT];

    always_ff @(posedge clk) begin
        if (rst || FrameStart)
            overflow_q <= 1'b0;
        else if (s2_vld_q && fifo_full && !pop)
            overflow_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= done_hit;
    end

    assign Overflow  = overflow_q;
    assign FrameDone = done_q;

endmodule
